// File: rtl/regfile_pkg.sv
// Shared register-file types and constants used by the read- and write-side masters.
package regfile_pkg;

   localparam int unsigned ADDR_W   = 4;
   localparam int unsigned DATA_W   = 8;
   localparam int unsigned NUM_REGS = 16;

   typedef logic [ADDR_W-1:0] rf_addr_t;
   typedef logic [DATA_W-1:0] rf_data_t;
   typedef logic [ADDR_W:0]   rf_cnt_t;

   typedef enum logic [1:0] {IDLE, READ, DRAIN} burst_state_t;

   // Burst length saturates at the register count so no address is read twice.
   function automatic rf_cnt_t clamp_count(rf_cnt_t c);
      return (c > rf_cnt_t'(NUM_REGS)) ? rf_cnt_t'(NUM_REGS) : c;
   endfunction

endpackage

// File: rtl/regfile_burst_out_stage.sv
// Single-entry valid/ready output register for the burst reader.
// Optional even-parity output under REGFILE_BURST_PARITY_EN.
module regfile_burst_out_stage
   import regfile_pkg::*;
(
   input  logic     clk_i,
   input  logic     rst_ni,
   input  logic     load_i,
   input  logic     ready_i,
   input  rf_data_t data_i,
   input  rf_addr_t addr_i,
   input  logic     last_i,
   output logic     valid_o,
   output rf_data_t data_o,
   output rf_addr_t addr_o,
   output logic     last_o
`ifdef REGFILE_BURST_PARITY_EN
   ,
   output logic     parity_o
`endif
);

   logic     valid_q, valid_d;
   rf_data_t data_q, data_d;
   rf_addr_t addr_q, addr_d;
   logic     last_q, last_d;
`ifdef REGFILE_BURST_PARITY_EN
   logic     parity_q, parity_d;
`endif

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      addr_d  = addr_q;
      last_d  = last_q;
`ifdef REGFILE_BURST_PARITY_EN
      parity_d = parity_q;
`endif
      if (load_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
         addr_d  = addr_i;
         last_d  = last_i;
`ifdef REGFILE_BURST_PARITY_EN
         parity_d = ^data_i;
`endif
      end else if (valid_q && ready_i) begin
         // Data and address stay as-is after acceptance; only the qualifiers drop.
         valid_d = 1'b0;
         last_d  = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         addr_q  <= '0;
         last_q  <= 1'b0;
`ifdef REGFILE_BURST_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         addr_q  <= addr_d;
         last_q  <= last_d;
`ifdef REGFILE_BURST_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign addr_o  = addr_q;
   assign last_o  = last_q;
`ifdef REGFILE_BURST_PARITY_EN
   assign parity_o = parity_q;
`endif

endmodule

// File: rtl/regfile_burst_reader.sv
// Burst read initiator for the 16x8 register file, streaming bytes out on valid/ready.
// Define REGFILE_BURST_PARITY_EN to add the m_parity_o output.
module regfile_burst_reader
   import regfile_pkg::*;
(
   input  logic     clk_i,
   input  logic     rst_ni,
   input  logic     start_i,
   input  rf_addr_t start_addr_i,
   input  rf_cnt_t  count_i,
   output logic     busy_o,
   output logic     done_o,
   output rf_addr_t rf_raddr_o,
   input  rf_data_t rf_rdata_i,
   output logic     m_valid_o,
   input  logic     m_ready_i,
   output rf_data_t m_data_o,
   output rf_addr_t m_addr_o,
   output logic     m_last_o
`ifdef REGFILE_BURST_PARITY_EN
   ,
   output logic     m_parity_o
`endif
);

   burst_state_t state_q, state_d;
   rf_addr_t     raddr_q, raddr_d;
   rf_cnt_t      remaining_q, remaining_d;
   logic         busy_q, busy_d;
   logic         done_q, done_d;
   logic         out_load;
   logic         out_valid;

   always_comb begin
      state_d     = state_q;
      raddr_d     = raddr_q;
      remaining_d = remaining_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      out_load    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               if (count_i != '0) begin
                  raddr_d     = start_addr_i;
                  remaining_d = clamp_count(count_i);
                  busy_d      = 1'b1;
                  state_d     = READ;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         READ: begin
            // A beat is captured whenever the output slot is empty or being drained.
            if (!out_valid || m_ready_i) begin
               out_load    = 1'b1;
               raddr_d     = raddr_q + 1'b1;
               remaining_d = remaining_q - 1'b1;
               if (remaining_q == rf_cnt_t'(1)) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (out_valid && m_ready_i) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         raddr_q     <= '0;
         remaining_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         raddr_q     <= raddr_d;
         remaining_q <= remaining_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   regfile_burst_out_stage u_out_stage (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .load_i   (out_load),
      .ready_i  (m_ready_i),
      .data_i   (rf_rdata_i),
      .addr_i   (raddr_q),
      .last_i   (remaining_q == rf_cnt_t'(1)),
      .valid_o  (out_valid),
      .data_o   (m_data_o),
      .addr_o   (m_addr_o),
      .last_o   (m_last_o)
`ifdef REGFILE_BURST_PARITY_EN
      ,
      .parity_o (m_parity_o)
`endif
   );

   assign m_valid_o  = out_valid;
   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign rf_raddr_o = raddr_q;

endmodule

// File: tb/tb_regfile_burst_reader.sv
// Directed bench for regfile_burst_reader with a behavioural 16x8 register file.
module tb_regfile_burst_reader;
   import regfile_pkg::*;

   logic     clk = 1'b0;
   logic     rst_n = 1'b0;
   logic     start = 1'b0;
   rf_addr_t start_addr = '0;
   rf_cnt_t  count = '0;
   logic     m_ready = 1'b0;
   logic     busy, done, m_valid, m_last;
   rf_addr_t rf_raddr, m_addr;
   rf_data_t rf_rdata, m_data;
`ifdef REGFILE_BURST_PARITY_EN
   logic     m_parity;
`endif

   rf_data_t regs   [NUM_REGS];
   rf_data_t golden [NUM_REGS];
   logic     preload = 1'b0;
   logic     we = 1'b0;
   rf_addr_t wa = '0;
   rf_data_t wd = '0;

   int unsigned n_checks = 0;
   int unsigned n_pass = 0;

   always #5 clk = ~clk;

   assign rf_rdata = regs[rf_raddr];

   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < int'(NUM_REGS); i++) regs[i] <= rf_data_t'(8'hA0 + i);
      end else if (we) begin
         regs[wa] <= wd;
      end
   end

   regfile_burst_reader dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .start_i      (start),
      .start_addr_i (start_addr),
      .count_i      (count),
      .busy_o       (busy),
      .done_o       (done),
      .rf_raddr_o   (rf_raddr),
      .rf_rdata_i   (rf_rdata),
      .m_valid_o    (m_valid),
      .m_ready_i    (m_ready),
      .m_data_o     (m_data),
      .m_addr_o     (m_addr),
      .m_last_o     (m_last)
`ifdef REGFILE_BURST_PARITY_EN
      ,
      .m_parity_o   (m_parity)
`endif
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Full burst with m_ready held high; optional stray start and one write racing a capture.
   task automatic run_burst(input rf_addr_t sa, input rf_cnt_t cnt, input bit spurious,
                            input int wr_beat, input rf_data_t wr_val);
      int       n;
      rf_addr_t a;
      n = (int'(cnt) > 16) ? 16 : int'(cnt);
      golden = regs;
      start = 1'b1; start_addr = sa; count = cnt; m_ready = 1'b1;
      tick();
      start = 1'b0;
      check_eq("busy_after_start", 32'(busy), 32'd1);
      check_eq("raddr_issue", 32'(rf_raddr), 32'(sa));
      check_eq("valid_latency", 32'(m_valid), 32'd0);
      if (spurious) begin
         start = 1'b1; start_addr = sa + 4'd5; count = 5'd2;
      end
      for (int i = 0; i < n; i++) begin
         if (i == wr_beat) begin
            we = 1'b1; wa = sa + rf_addr_t'(i); wd = wr_val;
         end
         tick();
         we = 1'b0;
         if (i >= 1) start = 1'b0;
         a = sa + rf_addr_t'(i);
         check_eq("beat_valid", 32'(m_valid), 32'd1);
         check_eq("beat_addr", 32'(m_addr), 32'(a));
         check_eq("beat_data", 32'(m_data), 32'(golden[a]));
         check_eq("beat_last", 32'(m_last), 32'(i == n - 1));
         check_eq("beat_no_done", 32'(done), 32'd0);
`ifdef REGFILE_BURST_PARITY_EN
         check_eq("beat_parity", 32'(m_parity), 32'(^golden[a]));
`endif
      end
      start = 1'b0;
      tick();
      check_eq("end_valid", 32'(m_valid), 32'd0);
      check_eq("end_done", 32'(done), 32'd1);
      check_eq("end_busy", 32'(busy), 32'd0);
      tick();
      check_eq("done_one_cycle", 32'(done), 32'd0);
      check_eq("idle_no_beat", 32'(m_valid), 32'd0);
      check_eq("idle_busy", 32'(busy), 32'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_busy"}, 32'(busy), 32'd0);
      check_eq({tag, "_done"}, 32'(done), 32'd0);
      check_eq({tag, "_raddr"}, 32'(rf_raddr), 32'd0);
      check_eq({tag, "_valid"}, 32'(m_valid), 32'd0);
      check_eq({tag, "_data"}, 32'(m_data), 32'd0);
      check_eq({tag, "_addr"}, 32'(m_addr), 32'd0);
      check_eq({tag, "_last"}, 32'(m_last), 32'd0);
`ifdef REGFILE_BURST_PARITY_EN
      check_eq({tag, "_parity"}, 32'(m_parity), 32'd0);
`endif
   endtask

   initial begin
      bit          rdy   [7] = '{1, 0, 0, 1, 0, 1, 1};
      bit          exp_v [7] = '{1, 1, 1, 1, 1, 1, 0};
      int          exp_a [7] = '{8, 8, 8, 9, 9, 10, 0};
      bit          exp_l [7] = '{0, 0, 0, 0, 0, 1, 0};
      bit          exp_d [7] = '{0, 0, 0, 0, 0, 0, 1};
      int unsigned accepted;

      preload = 1'b1;
      tick();
      tick();
      preload = 1'b0;
      check_all_zero("reset");
      rst_n = 1'b1;
      tick();

      // Full 16-beat dump from 0, then wrap-around from 14.
      run_burst(4'd0, 5'd16, 1'b0, -1, 8'h00);
      run_burst(4'd14, 5'd4, 1'b0, -1, 8'h00);

      // Backpressure: beats must hold while m_ready is low.
      start = 1'b1; start_addr = 4'd8; count = 5'd3; m_ready = 1'b1;
      tick();
      start = 1'b0;
      accepted = 0;
      for (int i = 0; i < 7; i++) begin
         m_ready = rdy[i];
         if (m_valid && m_ready) accepted++;
         tick();
         check_eq("bp_valid", 32'(m_valid), 32'(exp_v[i]));
         check_eq("bp_last", 32'(m_last), 32'(exp_l[i]));
         check_eq("bp_done", 32'(done), 32'(exp_d[i]));
         if (exp_v[i]) begin
            check_eq("bp_addr", 32'(m_addr), 32'(exp_a[i]));
            check_eq("bp_data", 32'(m_data), 32'(8'hA0 + exp_a[i]));
         end
      end
      check_eq("bp_beats", accepted, 32'd3);
      tick();
      check_eq("bp_done_clear", 32'(done), 32'd0);

      // Empty burst.
      start = 1'b1; start_addr = 4'd7; count = 5'd0;
      tick();
      start = 1'b0;
      check_eq("zero_done", 32'(done), 32'd1);
      check_eq("zero_busy", 32'(busy), 32'd0);
      check_eq("zero_valid", 32'(m_valid), 32'd0);
      tick();
      check_eq("zero_done_clear", 32'(done), 32'd0);
      check_eq("zero_valid2", 32'(m_valid), 32'd0);

      // Start pulsed while busy must not disturb the running burst.
      run_burst(4'd0, 5'd4, 1'b1, -1, 8'h00);

      // Write to reg 5 on the edge that captures it: old value streams out.
      run_burst(4'd3, 5'd4, 1'b0, 2, 8'h55);
      check_eq("snap_old_seen", 32'(golden[5]), 32'h0A5);
      run_burst(4'd5, 5'd1, 1'b0, -1, 8'h00);
      start = 1'b1; start_addr = 4'd5; count = 5'd1;
      tick();
      start = 1'b0;
      tick();
      check_eq("snap_new_value", 32'(m_data), 32'h55);
      tick();
      tick();

      // Oversized count clamps to 16 beats.
      run_burst(4'd3, 5'd20, 1'b0, -1, 8'h00);

      // Reset mid-burst, then a clean new burst.
      start = 1'b1; start_addr = 4'd0; count = 5'd8; m_ready = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      check_eq("pre_rst_addr", 32'(m_addr), 32'd2);
      rst_n = 1'b0;
      #1;
      check_all_zero("midrst");
      tick();
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("post_rst_valid", 32'(m_valid), 32'd0);
         check_eq("post_rst_done", 32'(done), 32'd0);
         check_eq("post_rst_busy", 32'(busy), 32'd0);
      end
      run_burst(4'd10, 5'd3, 1'b0, -1, 8'h00);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
